// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (MEM) requesters.
// Data accesses win arbitration. A burst limiter bounds how many data grants can pass a
// waiting fetch. Each access runs IDLE -> BUSY -> RESP, with a registered response and a
// timeout that reports a bus error.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_amp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [3:0] MaxBurst = 4'(MAX_D_BURST);
  // The last BUSY cycle has TIMEOUT-1 cycles already counted.
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic                own_d_q, own_d_d;   // 1: data port owns the access, 0: fetch port
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [3:0]          burst_q, burst_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                grant_d;

  // Next-state logic: arbitration, request latching, timeout and response capture.
  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    burst_d = burst_q;
    tmo_d   = tmo_q;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_req || i_req) begin
          // A data request yields only when a waiting fetch has used up its patience.
          grant_d = d_req && !(i_req && (burst_q == MaxBurst));
          state_d = StBusy;
          own_d_d = grant_d;
          tmo_d   = '0;
          err_d   = 1'b0;
          if (grant_d) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            be_d    = d_we ? d_amp : 4'b1111;
            burst_d = i_req ? burst_q + 4'd1 : 4'd0;
          end else begin
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            be_d    = 4'b1111;
            burst_d = 4'd0;
          end
        end
      end
      StBusy: begin
        tmo_d = tmo_q + 8'd1;
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        tmo_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and request/response registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      own_d_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      burst_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode from state so they fall to zero as soon as reset forces IDLE.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    i_ack     = 1'b0;
    i_rdata   = '0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    bus_err   = 1'b0;
    if (state_q == StBusy) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;
    end
    if (state_q == StResp) begin
      bus_err = err_q;
      if (own_d_q) begin
        d_ack   = 1'b1;
        d_rdata = rdata_q;
      end else begin
        i_ack   = 1'b1;
        i_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut0 uses MAX_D_BURST=4 and TIMEOUT=8.
// dut1 uses MAX_D_BURST=1 and is exercised only for fetch/data alternation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0 signals
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_amp;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, d_ack, bus_err, mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic        auto0, mr0;
  assign mem_ready = auto0 ? mem_req : mr0;

  // dut1 signals
  logic        i_req1, d_req1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        i_ack1, d_ack1, bus_err1, mem_req1, mem_we1;
  logic [3:0]  mem_be1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT(8)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_amp(d_amp),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(32'h0000_1000), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(1'b0), .d_addr(32'h0000_2000), .d_wdata(32'h0), .d_amp(4'h0),
    .d_rdata(d_rdata1), .d_ack(d_ack1), .bus_err(bus_err1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_be(mem_be1), .mem_rdata(32'h0000_5555), .mem_ready(mem_req1)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          cnt;
  int          nack;
  logic [15:0] seq;

  initial begin
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_amp = 0;
    mem_rdata = 0; auto0 = 0; mr0 = 0; i_req1 = 0; d_req1 = 0;

    // Reset state
    #12;
    check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_val("rst_acks", {29'b0, i_ack, d_ack, bus_err}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_rdata", i_rdata | d_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Fetch only, minimum latency
    i_req = 1; i_addr = 32'h100;
    tick();
    check_val("f_mem_req", {31'b0, mem_req}, 32'd1);
    check_val("f_mem_addr", mem_addr, 32'h100);
    check_val("f_we_be", {27'b0, mem_we, mem_be}, 32'h0F);
    mr0 = 1; mem_rdata = 32'h0050_0093;
    tick();
    check_val("f_i_ack", {31'b0, i_ack}, 32'd1);
    check_val("f_i_rdata", i_rdata, 32'h0050_0093);
    check_val("f_d_ack", {30'b0, d_ack, mem_req}, 32'd0);
    i_req = 0; mr0 = 0;
    tick();
    check_val("f_after", {31'b0, i_ack}, 32'd0);
    check_val("f_rdata_clr", i_rdata, 32'd0);

    // Store with lane mask, 3 wait cycles
    d_req = 1; d_we = 1; d_addr = 32'h202; d_wdata = 32'hABCD_0000; d_amp = 4'b1100;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_val("s_wait_req", {31'b0, mem_req}, 32'd1);
      check_val("s_we_be", {27'b0, mem_we, mem_be}, 32'h1C);
      check_val("s_wdata", mem_wdata, 32'hABCD_0000);
      check_val("s_addr", mem_addr, 32'h202);
      tick();
    end
    mr0 = 1;
    tick();
    check_val("s_d_ack", {30'b0, d_ack, i_ack}, 32'd2);
    check_val("s_d_rdata", d_rdata, 32'd0);
    d_req = 0; d_we = 0; mr0 = 0;
    tick();
    check_val("s_after", {31'b0, d_ack}, 32'd0);

    // Timeout, mem_ready never comes
    d_req = 1; d_addr = 32'h300;
    tick();
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      tick();
    end
    check_val("t_busy_cycles", cnt, 32'd8);
    check_val("t_ack_err", {30'b0, d_ack, bus_err}, 32'd3);
    check_val("t_rdata", d_rdata, 32'd0);
    d_req = 0;
    tick();
    check_val("t_err_clr", {31'b0, bus_err}, 32'd0);

    // mem_ready on the 8th BUSY cycle counts as success
    d_req = 1; mem_rdata = 32'h0000_1234;
    tick();
    for (int k = 0; k < 7; k++) tick();
    check_val("t8_still_busy", {31'b0, mem_req}, 32'd1);
    mr0 = 1;
    tick();
    check_val("t8_ack_noerr", {30'b0, d_ack, bus_err}, 32'd2);
    check_val("t8_rdata", d_rdata, 32'h0000_1234);
    d_req = 0; mr0 = 0;
    tick();

    // Reset during the second wait cycle
    i_req = 1; i_addr = 32'h340;
    tick();
    tick();
    check_val("r_busy", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("r_async", {28'b0, mem_req, i_ack, d_ack, bus_err}, 32'd0);
    check_val("r_addr_clr", mem_addr, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    check_val("r_regrant", {31'b0, mem_req}, 32'd1);
    check_val("r_regrant_addr", mem_addr, 32'h340);
    mr0 = 1; mem_rdata = 32'h0000_0042;
    tick();
    check_val("r_i_ack", i_rdata, 32'h0000_0042);
    i_req = 0; mr0 = 0;
    tick();

    // Dropped data request still completes; pending fetch follows
    d_req = 1; d_addr = 32'h400; i_req = 1; i_addr = 32'h500;
    tick();
    check_val("x_d_first", mem_addr, 32'h400);
    d_req = 0;
    tick();
    mr0 = 1; mem_rdata = 32'h0000_0077;
    tick();
    check_val("x_d_ack", {30'b0, d_ack, i_ack}, 32'd2);
    check_val("x_d_rdata", d_rdata, 32'h0000_0077);
    mr0 = 0;
    tick();
    check_val("x_idle", {31'b0, mem_req}, 32'd0);
    tick();
    check_val("x_i_addr", mem_addr, 32'h500);
    mr0 = 1;
    tick();
    check_val("x_i_ack", {31'b0, i_ack}, 32'd1);
    i_req = 0; mr0 = 0;
    tick();

    // Contention on dut0: expect D,D,D,D,I,D,D,D,D,I (1 = data ack)
    auto0 = 1; i_req = 1; d_req = 1; d_we = 0;
    seq = 0; nack = 0; cnt = 0;
    while (nack < 10 && cnt < 200) begin
      tick();
      cnt++;
      if (d_ack) begin seq = {seq[14:0], 1'b1}; nack++; end
      else if (i_ack) begin seq = {seq[14:0], 1'b0}; nack++; end
    end
    i_req = 0; d_req = 0;
    check_val("c_nack", nack, 32'd10);
    check_val("c_seq", {22'b0, seq[9:0]}, 32'h3DE);
    for (int k = 0; k < 4; k++) tick();
    auto0 = 0;

    // Contention on dut1 (burst limit 1): expect D,I,D,I,D,I
    i_req1 = 1; d_req1 = 1;
    seq = 0; nack = 0; cnt = 0;
    while (nack < 6 && cnt < 200) begin
      tick();
      cnt++;
      if (d_ack1) begin seq = {seq[14:0], 1'b1}; nack++; end
      else if (i_ack1) begin seq = {seq[14:0], 1'b0}; nack++; end
    end
    i_req1 = 0; d_req1 = 0;
    check_val("c1_nack", nack, 32'd6);
    check_val("c1_seq", {26'b0, seq[5:0]}, 32'h2A);
    for (int k = 0; k < 4; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined core.
- Data accesses have priority, because MEM holds the older instruction. A burst limiter stops instruction fetch from starving.
- Sequences a stable-until-ready memory handshake and registers the response.
- Raises a bus error on memory timeout. The pipeline stalls a stage while its req is high and its ack has not arrived.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_BURST, 4, max consecutive data grants while an instruction fetch waits (range 1..15)
TIMEOUT, 255, max cycles in BUSY waiting for mem_ready (range 1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data; valid while i_ack=1
i_ack  out  1  one-cycle completion pulse to IF
d_req  in  1  data request; held with d_* until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_amp  in  4  store byte-lane mask
d_rdata  out  DATA_W  load data; valid while d_ack=1
d_ack  out  1  one-cycle completion pulse to MEM
bus_err  out  1  pulses together with the ack of a timed-out access
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  byte enables
mem_rdata  in  DATA_W  memory read data; valid while mem_ready=1
mem_ready  in  1  memory completion; sampled only while mem_req=1

Behaviour:
- Reset (reset=0, any time, including mid-access) has an immediate, asynchronous effect:
  - state=IDLE;
  - every output 0, including mem_* and both rdata outputs;
  - burst counter and timeout counter cleared.
  - An outstanding memory access is abandoned. The memory tolerates mem_req dropping.
- FSM states: IDLE, BUSY, RESP. Grant owner register: I or D.
- IDLE:
  - no req: stay in IDLE.
  - only d_req: grant D.
  - only i_req: grant I.
  - both: grant D, unless the burst counter = MAX_D_BURST, in which case grant I.
  - On a grant, latch addr, wdata, we and be into the request registers, then go to BUSY.
  - I grant latches we=0, be=4'b1111, wdata=0.
  - D load latches we=0, be=4'b1111. D store latches we=1, be=d_amp.
- Burst counter, updated at each grant:
  - D grant with i_req=1: increment.
  - I grant, or D grant with i_req=0: clear.
- BUSY:
  - mem_req=1; mem_we/addr/wdata/be driven from the request registers, stable for the whole state.
  - Timeout counter increments each BUSY cycle.
  - mem_ready=1: capture mem_rdata (loads and fetches; stores capture 0), then go to RESP.
  - Counter reaches TIMEOUT with mem_ready=0: capture 0, set the error flag, go to RESP.
  - mem_ready in the same cycle as the TIMEOUT count: treated as success.
- RESP:
  - mem_req=0.
  - Exactly one cycle: owner's ack=1 and owner's rdata = captured value; bus_err = error flag.
  - Non-owner ack and rdata stay 0. rdata returns to 0 after RESP.
  - Then go to IDLE; timeout counter and error flag clear.
  - Requests are not sampled in RESP (the acked req is still high that cycle).
- Timing:
  - Minimum latency, req to ack: 2 cycles when mem_ready is high in the first BUSY cycle. Cycle 0 IDLE grant, cycle 1 BUSY, cycle 2 RESP.
  - Back-to-back accesses: one request per 3 cycles minimum.
- Requester rules:
  - Requesters do not change addr/data while req=1. The arbiter uses latched copies only.
  - A req dropped before its ack still completes internally and still pulses ack.
- Ignored inputs: mem_ready in IDLE or RESP.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; mem_ready=1 one cycle after mem_req, mem_rdata=0x00500093 -> mem_req cycle 1 with addr 0x100, we=0, be=1111; i_ack pulse cycle 2 with i_rdata=0x00500093; d_ack stays 0.
- Store with lane mask: d_req=1, d_we=1, d_addr=0x202, d_wdata=0xABCD0000, d_amp=1100 -> mem_we=1, mem_be=1100, mem_wdata=0xABCD0000 held through 3 wait cycles; d_ack once, d_rdata=0.
- Contention and starvation: i_req and d_req held high, d_req re-raised right after each d_ack -> grants D,D,D,D,I; burst counter cleared after the I grant. With MAX_D_BURST=1 -> grants alternate D,I.
- Timeout: TIMEOUT=8, mem_ready held 0 -> mem_req high for exactly 8 cycles, then d_ack=1 with bus_err=1 and d_rdata=0. Same test with mem_ready=1 on the 8th cycle -> bus_err=0.
- Reset mid-BUSY: reset=0 during the second wait cycle -> mem_req, acks and bus_err go to 0 immediately. After release, a pending i_req gets a fresh grant 1 cycle later.
- Dropped request: d_req deasserted during BUSY -> access completes and d_ack still pulses; the next IDLE grants a pending i_req.
